// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan display driver.
//   SEG_0..SEG_9, SEG_DASH : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   DIG_*                  : scan slot indices; slot number also selects the sel bit
package seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [1:0] DIG_DOT = 2'd0;
    localparam logic [1:0] DIG_ONE = 2'd1;
    localparam logic [1:0] DIG_TEN = 2'd2;
    localparam logic [1:0] DIG_HUN = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment pattern, purely combinational.
//   digit   : 4-bit code; 0-9 give the numeral, 10-15 give a dash
//   pattern : active-high {g,f,e,d,c,b,a}
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (digit)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 4-digit 7-segment driver showing "HHH.D".
//   clk, rst_n          : clock, async-assert / sync-release active-low reset
//   hun, ten, one, dot  : BCD digits, snapshotted once per scan frame
//   blank               : force display dark for a frame (sampled at frame start)
//   seg                 : {dp,g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//   sel                 : one-hot digit enable, sel[3]=hun .. sel[0]=dot
//   frame_start         : one-cycle pulse alongside the first slot of a frame
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hun,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    input  logic [3:0] dot,
    input  logic       blank,
    output logic [7:0] seg,
    output logic [3:0] sel,
    output logic       frame_start
);

    if (SCAN_DIV < 2) begin : g_bad_div
        $fatal(1, "seg_scan: SCAN_DIV must be 2 or more");
    end

    localparam int              CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
    // XOR masks: inactive level and output inversion are the same constant
    localparam logic [7:0]      SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0]      SEL_OFF = (ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

    logic          run;       // goes high one edge after rst_n releases
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   snap;      // {hun,ten,one,dot}
    logic          blank_q;

    logic          tick, fstart;
    logic [1:0]    nidx;
    logic [15:0]   src;
    logic          blk_src, lz_off;
    logic [3:0]    digit;
    logic [6:0]    pattern;
    logic [7:0]    pat;

    // Release synchroniser: assertion is immediate, release waits for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    assign tick   = run && (cnt == CNT_MAX);
    assign nidx   = idx + 2'd1;
    assign fstart = tick && (idx == DIG_HUN);

    // The frame-start slot is fed from the live inputs because the snapshot
    // is being written in the same edge.
    always_comb begin
        src     = fstart ? {hun, ten, one, dot} : snap;
        blk_src = fstart ? blank : blank_q;
        digit   = src[{nidx, 2'b00} +: 4];
        lz_off  = (LZ_BLANK != 0) &&
                  (((nidx == DIG_HUN) && (src[15:12] == 4'd0)) ||
                   ((nidx == DIG_TEN) && (src[15:8]  == 8'd0)));
        pat     = (blk_src || lz_off) ? 8'h00 : {nidx == DIG_ONE, pattern};
    end

    seg7_decode u_dec (
        .digit   (digit),
        .pattern (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= DIG_HUN;
            snap        <= '0;
            blank_q     <= 1'b1;
            frame_start <= 1'b0;
            seg         <= SEG_OFF;
            sel         <= SEL_OFF;
        end else if (run) begin
            cnt         <= tick ? '0 : cnt + CW'(1);
            frame_start <= fstart;
            if (tick) begin
                idx <= nidx;
                seg <= pat ^ SEG_OFF;
                sel <= (4'b0001 << nidx) ^ SEL_OFF;
            end
            if (fstart) begin
                snap    <= {hun, ten, one, dot};
                blank_q <= blank;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: three instances (common-anode with and
// without leading-zero blanking, common-cathode) share one stimulus stream.
module tb_seg_scan;

    localparam int SD = 4;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hun = 0, ten = 0, one = 0, dot = 0;
    logic       blank = 1'b0;

    logic [7:0] seg_al, seg_lz, seg_ah;
    logic [3:0] sel_al, sel_lz, sel_ah;
    logic       fs_al, fs_lz, fs_ah;

    int checks = 0;
    int failures = 0;

    // {blank,hun,ten,one,dot} that the frame currently on display was taken from
    logic [16:0] cur;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1), .LZ_BLANK(1)) u_al (
        .clk(clk), .rst_n(rst_n), .hun(hun), .ten(ten), .one(one), .dot(dot),
        .blank(blank), .seg(seg_al), .sel(sel_al), .frame_start(fs_al));
    seg_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1), .LZ_BLANK(0)) u_lz (
        .clk(clk), .rst_n(rst_n), .hun(hun), .ten(ten), .one(one), .dot(dot),
        .blank(blank), .seg(seg_lz), .sel(sel_lz), .frame_start(fs_lz));
    seg_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(0), .LZ_BLANK(1)) u_ah (
        .clk(clk), .rst_n(rst_n), .hun(hun), .ten(ten), .one(one), .dot(dot),
        .blank(blank), .seg(seg_ah), .sel(sel_ah), .frame_start(fs_ah));

    // ---------------- reference model (display rules, per slot) ----------------
    function automatic logic [6:0] m_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
            5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    // slot 0=dot, 1=one, 2=ten, 3=hun
    function automatic logic [7:0] m_seg(input logic [16:0] st, input int slot,
                                         input bit al, input bit lz);
        logic [3:0] h, t, d;
        logic [7:0] v;
        bit off;
        h = st[15:12];
        t = st[11:8];
        case (slot)
            0: d = st[3:0];
            1: d = st[7:4];
            2: d = st[11:8];
            default: d = st[15:12];
        endcase
        off = st[16] || (lz && slot == 3 && h == 0) || (lz && slot == 2 && h == 0 && t == 0);
        v = off ? 8'h00 : {slot == 1, m_pat(d)};
        return al ? ~v : v;
    endfunction

    function automatic logic [3:0] m_sel(input int slot, input bit al);
        logic [3:0] v;
        v = 4'(1 << slot);
        return al ? ~v : v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [16:0] v);
        {blank, hun, ten, one, dot} = v;
    endtask

    function automatic logic [16:0] rnd_in();
        logic [16:0] v;
        v[16] = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < 4; i++)
            v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Called at the negedge where frame_start is expected. Checks every cycle of
    // one frame, optionally scrambles the inputs before cycle chg, then applies
    // nxt at cycle chg so the next frame start snapshots it.
    task automatic run_frame(input logic [16:0] nxt, input bit noise, input int chg,
                             input bit has_tab, input logic [3:0][7:0] tab);
        int s;
        for (int c = 0; c < FR; c++) begin
            s = c / SD;
            chk("frame_start", {29'd0, fs_al, fs_lz, fs_ah}, {29'd0, {3{c == 0}}});
            chk("sel_al", {28'd0, sel_al}, {28'd0, m_sel(s, 1)});
            chk("seg_al", {24'd0, seg_al}, {24'd0, m_seg(cur, s, 1, 1)});
            chk("sel_lz", {28'd0, sel_lz}, {28'd0, m_sel(s, 1)});
            chk("seg_lz", {24'd0, seg_lz}, {24'd0, m_seg(cur, s, 1, 0)});
            chk("sel_ah", {28'd0, sel_ah}, {28'd0, m_sel(s, 0)});
            chk("seg_ah", {24'd0, seg_ah}, {24'd0, m_seg(cur, s, 0, 1)});
            if (has_tab && (c % SD) == 0) begin
                chk("tab_seg_al", {24'd0, seg_al}, {24'd0, ~tab[s]});
                chk("tab_seg_ah", {24'd0, seg_ah}, {24'd0, tab[s]});
            end
            if (noise && c < chg) drive(rnd_in());
            if (c == chg) drive(nxt);
            @(negedge clk);
        end
        cur = nxt;
    endtask

    // Release reset at a negedge and time the first output change.
    task automatic release_and_time();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (sel_al == 4'hF && n <= 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_change_cycles", n, SD + 1);
        chk("first_sel_dot", {28'd0, sel_al}, 32'hE);
        chk("first_frame_start", {31'd0, fs_al}, 32'd1);
        if (n > 40) begin
            $display("FAIL reset_release_timeout got=no_change expected=change");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "timeout");
        end
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [16:0]     in;   // {blank,hun,ten,one,dot}
        logic [3:0][7:0] exp;  // active-high seg per slot, index = slot
    } vec_t;

    vec_t tab[8];

    initial begin
        // [0]=dot slot, [1]=one, [2]=ten, [3]=hun
        tab[0] = '{17'h0_1234, {8'h06, 8'h5B, 8'hCF, 8'h66}};  // basic
        tab[1] = '{17'h0_0005, {8'h00, 8'h00, 8'hBF, 8'h6D}};  // leading zeros
        tab[2] = '{17'h0_0C34, {8'h00, 8'h40, 8'hCF, 8'h66}};  // ten non-BCD
        tab[3] = '{17'h1_1234, {8'h00, 8'h00, 8'h00, 8'h00}};  // blanked
        tab[4] = '{17'h0_1234, {8'h06, 8'h5B, 8'hCF, 8'h66}};  // blank released
        tab[5] = '{17'h0_C000, {8'h40, 8'h3F, 8'hBF, 8'h3F}};  // hun non-BCD is non-zero
        tab[6] = '{17'h0_1234, {8'h06, 8'h5B, 8'hCF, 8'h66}};  // mid-frame change source
        tab[7] = '{17'h0_9876, {8'h6F, 8'h7F, 8'h87, 8'h7D}};  // mid-frame change target

        drive(tab[0].in);
        #12;
        chk("rst_sel_al", {28'd0, sel_al}, 32'hF);
        chk("rst_seg_al", {24'd0, seg_al}, 32'hFF);
        chk("rst_sel_ah", {28'd0, sel_ah}, 32'h0);
        chk("rst_seg_ah", {24'd0, seg_ah}, 32'h0);
        chk("rst_fs", {29'd0, fs_al, fs_lz, fs_ah}, 32'd0);

        cur = tab[0].in;
        release_and_time();

        for (int i = 0; i < 6; i++)
            run_frame(tab[i+1].in, 1'b0, FR - 3, 1'b1, tab[i].exp);
        // tab[6] is on display: switch to 9876 during the one slot
        run_frame(tab[7].in, 1'b0, SD + 1, 1'b1, tab[6].exp);
        run_frame(17'h0_1234, 1'b0, FR - 3, 1'b1, tab[7].exp);

        // reset during the ten slot
        for (int c = 0; c < 2 * SD + 1; c++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sel_al", {28'd0, sel_al}, 32'hF);
        chk("midrst_seg_al", {24'd0, seg_al}, 32'hFF);
        chk("midrst_sel_ah", {28'd0, sel_ah}, 32'h0);
        chk("midrst_seg_ah", {24'd0, seg_ah}, 32'h0);
        chk("midrst_fs", {29'd0, fs_al, fs_lz, fs_ah}, 32'd0);
        drive(17'h0_0507);
        cur = 17'h0_0507;
        @(negedge clk);
        release_and_time();

        // randomized frames with input scrambling between frame starts
        for (int f = 0; f < 40; f++)
            run_frame(rnd_in(), 1'b1, $urandom_range(1, FR - 3), 1'b0, '0);
        run_frame(17'h0_0000, 1'b0, FR - 3, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Consumes the four BCD digits (hun, ten, one, dot) produced by the binary-to-BCD stage of the scale datapath.
- Drives a 4-digit multiplexed 7-segment display as "HHH.D", for example 123.4.
- Time-multiplexes the digits with a programmable refresh divider.
- Snapshots the digits once per scan frame so a mid-frame input change never tears the display, blanks leading zeros, and lights the decimal point on the units digit.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range is 2 or more.
- ACTIVE_LOW, 1, 1 = common-anode (seg and sel active-low), 0 = common-cathode (active-high).
- LZ_BLANK, 1, 1 = blank leading zeros on hun/ten, 0 = always show all digits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hun  in  4  hundreds BCD digit
- ten  in  4  tens BCD digit
- one  in  4  units BCD digit
- dot  in  4  tenths BCD digit
- blank  in  1  1 = force all digits off (sampled at frame start)
- seg  out  8  segment drive {dp,g,f,e,d,c,b,a}
- sel  out  4  digit enables, one-hot: sel[3]=hun, sel[2]=ten, sel[1]=one, sel[0]=dot
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async assert, sync release): div counter=0, idx=3, snapshot=0, blank_q=1, frame_start=0. sel and seg are inactive: all-ones when ACTIVE_LOW=1, all-zeros when ACTIVE_LOW=0.
- Divider: the counter counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle the count equals SCAN_DIV-1. The first tick is SCAN_DIV cycles after reset release.
- On tick: idx <= idx+1 mod 4, giving scan order dot, one, ten, hun, dot, and so on.
- On a tick with idx==3 (frame start): snapshot <= {hun,ten,one,dot}, blank_q <= blank, and frame_start=1 in the following cycle.
- All outputs are registered and update in the cycle after the tick. A frame-start slot uses the freshly sampled live inputs; the other slots use the snapshot.
- Inputs that change between frame starts never reach seg.
- Digit decode: 0-9 map to standard patterns. Active-high {g..a} values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any code 10-15 shows "-" (40).
- Decimal point: set only while the one digit is selected.
- Leading-zero blanking (LZ_BLANK=1):
  - hun is blanked if hun==0.
  - ten is blanked if hun==0 and ten==0.
  - one and dot are never blanked.
  - Blanked means the segments are all off, including dp; sel still cycles.
  - A non-BCD hun (10-15) counts as non-zero.
- blank_q=1: every slot shows all segments off for the whole frame, while sel keeps cycling.
- Polarity: the active-high pattern is computed internally and inverted at the output register when ACTIVE_LOW=1.
- rst_n asserted mid-frame: outputs go inactive immediately. On release, scanning restarts from the first tick with a fresh snapshot.
- Sim-time check: SCAN_DIV < 2 is a fatal error.

Decomposition:
- Shared package seg_pkg holds:
  - the segment pattern constants SEG_0..SEG_9 and SEG_DASH (active-high, {g..a});
  - digit-index constants DIG_DOT=0, DIG_ONE=1, DIG_TEN=2, DIG_HUN=3.
- One combinational sub-module seg7_decode: a 4-bit digit in, 7-bit active-high pattern out, with 10-15 mapping to dash.
- Divider, index, snapshot, blanking and the output register stay in seg_scan.

Test Plan:
- Basic display: SCAN_DIV=4, ACTIVE_LOW=1, inputs 1,2,3,4, blank=0.
  - Slots in order: sel=1110/seg=~66; sel=1101/seg=~CF (dp on); sel=1011/seg=~5B; sel=0111/seg=~06.
  - Each slot lasts 4 cycles; frame_start pulses once every 16 cycles.
- Leading zeros: inputs 0,0,0,5.
  - dot slot = ~6D; one slot = ~BF (zero with dp); ten and hun slots = FF.
  - Same inputs with LZ_BLANK=0: ten and hun slots = ~3F.
- Mid-frame change: inputs go from 1,2,3,4 to 9,8,7,6 during the one slot.
  - The rest of that frame still shows 1,2,3.
  - The next frame shows 9,8,7,6 starting at its dot slot (~7D).
- Non-BCD and blank:
  - ten=12 → ten slot = ~40 (dash).
  - blank=1 at a frame start → all four slots have seg=FF while sel still cycles.
  - blank deasserted → the display returns at the next frame start.
- Reset mid-operation: assert rst_n low during the ten slot.
  - sel=1111 and seg=FF immediately, with no clock edge needed.
  - After release, the first output change comes exactly SCAN_DIV+1 cycles later, with dot selected.
- Polarity: ACTIVE_LOW=0 with inputs 1,2,3,4 → dot slot sel=0001/seg=66, one slot seg=CF.
